// File: rtl/timer_pkg.sv
// Shared encodings for the bus timer: FSM states, register offsets, CTRL layout and modes.
package timer_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CNT  = 2'd1;
  localparam logic [1:0] ST_INT  = 2'd2;

  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PRESET = 2'd1;
  localparam logic [1:0] ADDR_COUNT  = 2'd2;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_if.sv
// Bridge-to-timer register bus: word offset, write strobe/data, combinational read data and irq.
interface timer_if #(parameter int WIDTH = 32);
  logic [1:0]       addr;
  logic             we;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             irq;

  modport master (output addr, we, din, input dout, irq);
  modport slave  (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_regfile.sv
// CTRL/PRESET storage, write decode, sticky PEND with clear-on-write, readback mux.
// Writes land on the next edge, reads are combinational; no backpressure.
module timer_regfile
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [WIDTH-1:0] din,
  input  logic [WIDTH-1:0] count,
  input  logic             en_clr,
  input  logic             pend_set,
  input  logic             pend_clr,
  output logic             en,
  output logic             im,
  output logic             reload,
  output logic [WIDTH-1:0] preset,
  output logic             pend,
  output logic [WIDTH-1:0] dout
);

  ctrl_t ctrl_q;
  logic  wr_ctrl;
  logic  wr_preset;

  assign wr_ctrl   = we && (addr == ADDR_CTRL);
  assign wr_preset = we && (addr == ADDR_PRESET);

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q <= '0;
      preset <= '0;
      pend   <= 1'b0;
    end else begin
      // A software CTRL write overrides the FSM's end-of-one-shot EN clear.
      if (wr_ctrl) begin
        ctrl_q.en <= din[CTRL_EN];
        ctrl_q.im <= din[CTRL_IM];
`ifdef TIMER_AUTO_RELOAD_EN
        ctrl_q.mode <= din[CTRL_MODE_HI:CTRL_MODE_LO];
`endif
      end else if (en_clr) begin
        ctrl_q.en <= 1'b0;
      end

      if (wr_preset) begin
        preset <= din;
      end

      if (pend_set) begin
        pend <= 1'b1;
      end else if (wr_ctrl || wr_preset || pend_clr) begin
        pend <= 1'b0;
      end
    end
  end

  assign en = ctrl_q.en;
  assign im = ctrl_q.im;

`ifdef TIMER_AUTO_RELOAD_EN
  assign reload = (ctrl_q.mode == MODE_RELOAD);
`else
  assign reload = 1'b0;
`endif

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout[3:0] = ctrl_q;
      ADDR_PRESET: dout      = preset;
      ADDR_COUNT:  dout      = count;
      default:     dout      = '0;
    endcase
  end

endmodule

// File: rtl/timer_dev.sv
// 32-bit down-counting bus timer, one-shot or auto-reload (TIMER_AUTO_RELOAD_EN) with maskable irq.
// Register writes take 1 edge, reads are combinational; no backpressure.
module timer_dev
  import timer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  timer_if.slave bus
);

  logic [1:0]       state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] preset;
  logic             en;
  logic             im;
  logic             reload;
  logic             pend;
  logic             pend_set;
  logic             en_clr;
  logic             pend_clr;

  timer_regfile #(.WIDTH(WIDTH)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .addr     (bus.addr),
    .we       (bus.we),
    .din      (bus.din),
    .count    (count),
    .en_clr   (en_clr),
    .pend_set (pend_set),
    .pend_clr (pend_clr),
    .en       (en),
    .im       (im),
    .reload   (reload),
    .preset   (preset),
    .pend     (pend),
    .dout     (bus.dout)
  );

  // COUNT of 0 or 1 both terminate, so PRESET=0 acts like PRESET=1 and never wraps.
  assign pend_set = (state == ST_CNT) && en && (count <= WIDTH'(1));
  assign en_clr   = (state == ST_INT) && !reload;
  assign pend_clr = (state == ST_INT) && reload;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (en) begin
            count <= preset;
            state <= ST_CNT;
          end
        end
        ST_CNT: begin
          if (!en) begin
            state <= ST_IDLE;
          end else if (count <= WIDTH'(1)) begin
            count <= '0;
            state <= ST_INT;
          end else begin
            count <= count - WIDTH'(1);
          end
        end
        ST_INT: begin
`ifdef TIMER_AUTO_RELOAD_EN
          if (reload) begin
            count <= preset;
            state <= ST_CNT;
          end else begin
            state <= ST_IDLE;
          end
`else
          state <= ST_IDLE;
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.irq = im & pend;

endmodule

// File: doc/timer_dev.md
# timer_dev

Programmable 32-bit down-counting timer on the processor bus, downstream of the `mips` core. The system bridge decodes byte range 0x0000_7F00–0x0000_7F0B and forwards `PrAddr[3:2]`, the write strobe and the write data to this block. The bridge returns `dout` to the core's `PrDIn`, and `irq` drives `HWInt[2]`. The block provides one-shot and auto-reload counting with a maskable interrupt.

## Interface
- `WIDTH`, default 32: width of the PRESET and COUNT registers and of the data ports.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `addr` input, 2 bits: word offset. 0 = CTRL, 1 = PRESET, 2 = COUNT, 3 = reserved.
- `we` input, 1 bit: write strobe, already qualified by the bridge's address decode. Writes are full-word only.
- `din` input, WIDTH bits: write data.
- `dout` output, WIDTH bits: read data, combinational from `addr`.
- `irq` output, 1 bit: interrupt request, registered.

## Operation
- **CTRL register** (read/write):
  - bit0 EN (enable).
  - bits[2:1] MODE: 00 = one-shot, 01 = auto-reload, 1x = treated as 00.
  - bit3 IM (interrupt mask, 1 = enabled).
  - bits[31:4] are ignored on write and read back as 0.
- **PRESET** (read/write): reload value.
- **COUNT** (read-only): current count. Writes to COUNT or to offset 3 are ignored. Offset 3 reads 0.
- **`irq` definition:** `irq` = IM & PEND, where PEND is an internal sticky flag.
- **FSM states:** IDLE, CNT, INT.
  - **IDLE:** if EN=1, set COUNT <= PRESET and go to CNT.
  - **CNT:** if EN=0, go to IDLE and COUNT holds its value. Otherwise:
    - If COUNT <= 1: COUNT <= 0, PEND <= 1, go to INT.
    - Else: COUNT <= COUNT - 1.
  - **INT, MODE 00:** EN <= 0, go to IDLE. PEND stays 1 until any write to CTRL or PRESET clears it.
  - **INT, MODE 01:** PEND <= 0, COUNT <= PRESET, go to CNT. This produces a 1-cycle `irq` pulse.
- **Arithmetic:** unsigned, WIDTH bits. PRESET=0 behaves exactly like PRESET=1, so the counter never wraps.
- **Mid-count PRESET write:** does not affect the running count. It takes effect on the next load.
- **Simultaneous events:**
  - A CTRL or PRESET write on the same edge that sets PEND: the event wins and PEND becomes 1. The written register value is still stored.
  - A software write to CTRL on the INT→IDLE edge: the software value wins over the automatic EN clear.
- **Reset:**
  - Values after reset: CTRL = 0, PRESET = 0, COUNT = 0, PEND = 0, state = IDLE, `irq` = 0, `dout` = 0.
  - Reset mid-count aborts immediately, with no interrupt.

## Timing
- Write-to-register latency: 1 edge.
- Read latency: 0 cycles (combinational `dout`).
- Counting from a write at edge E0 that sets EN=1 with PRESET=N (N >= 1):
  - E1: COUNT=N, state CNT.
  - E(1+N): COUNT=0 and PEND=1.
  - `irq` is high from E(1+N) onward when IM=1.
- Auto-reload period: N+1 cycles between `irq` pulses.
- One-shot: `irq` stays high until cleared by a CTRL or PRESET write. It drops 1 edge after that write.

## Configuration
- **`TIMER_AUTO_RELOAD_EN` defined:** MODE bits are writable and MODE 01 behaves as described above.
- **Not defined:**
  - MODE bits ignore writes and read 0.
  - The timer operates in one-shot mode only.
  - The INT-state reload path is absent.

## Structure
- Package `timer_pkg` contains:
  - State encoding (IDLE, CNT, INT).
  - Register offsets (CTRL=0, PRESET=1, COUNT=2).
  - CTRL bit positions (EN, MODE, IM).
  - Mode constants.
- One sub-module: `timer_regfile`. It holds CTRL/PRESET storage, write decode, PEND clear-on-write, and the readback mux.
- FSM and counter stay in `timer_dev`.

## Test plan
- **Reset:** assert `rst` mid-count with COUNT=7 → next edge: COUNT=0, `irq`=0, `dout`@CTRL = 0.
- **One-shot:** PRESET=5, then CTRL=0x9 (EN, IM) → `irq` rises exactly 6 edges after the CTRL write edge. EN then reads 0 and `irq` holds high. Writing PRESET=5 clears `irq` on the next edge.
- **Auto-reload:** PRESET=3, CTRL=0xB → `irq` 1-cycle pulses every 4 cycles. COUNT reads 3, 2, 1, 0, 3, …
- **Mask:** CTRL=0x1 (IM=0), PRESET=2 → COUNT reaches 0 and `irq` stays 0. Writing CTRL=0x8 afterwards clears PEND, so `irq` stays 0.
- **Boundary:** PRESET=0 with EN=1 → INT after 1 CNT cycle, identical to PRESET=1. Disabling mid-count at COUNT=4 holds COUNT=4 with no `irq`.
- **Collision:** a CTRL write on the same edge PEND sets → `irq`=1 afterwards. Without `TIMER_AUTO_RELOAD_EN`, writing CTRL=0xB reads back 0x9.
